bus_cycle_decoder: RTL and testbench

Parametrised 6502 bus-cycle decoder for the front-panel FPGA. It samples the asynchronous CPU bus (PHI2, RW, SYNC, A, D) into the 25 MHz domain and detects PHI2 edges. It decodes NWIN prioritised address windows and emits one-clock read/write strobes with captured address and data. It also counts bus cycles and stretches single-step requests into a minimum-width NMI pulse. It replaces the ad-hoc PHI2 tracking, write strobe and NMI counter in the top level.

---
 rtl/bus_cycle_decoder.sv | 191 +++++++++++++++++++
 tb/tb_bus_cycle_decoder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_decoder.sv
// 6502 bus-cycle decoder: samples the async CPU bus, finds PHI2 edges, decodes prioritised
// address windows, counts bus cycles and stretches single-step requests into an NMI pulse.
// Define BUS_CYCLE_DECODER_OPFETCH_EN to build the SYNC path and opfetch_stb.
`timescale 1ns/1ps
module bus_cycle_decoder #(
    parameter int                     ADDR_W      = 16,
    parameter int                     DATA_W      = 8,
    parameter int                     NWIN        = 2,
    // window 0 = FPGA page 0xFF00 (highest priority), window 1 = RAM in the upper half
    parameter logic [NWIN*ADDR_W-1:0] WIN_MASK    = {16'h8000, 16'hFF00},
    parameter logic [NWIN*ADDR_W-1:0] WIN_PATTERN = {16'h8000, 16'hFF00},
    parameter int                     SYNC_STAGES = 2,
    parameter int                     NMI_WIDTH   = 128,
    parameter int                     CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phi2_async,
    input  logic              rw_async,
    input  logic              sync_async,
    input  logic [ADDR_W-1:0] a_async,
    input  logic [DATA_W-1:0] d_async,
    input  logic              step_req,
    output logic [NWIN-1:0]   win_hit,
    output logic [NWIN-1:0]   rd_stb,
    output logic [NWIN-1:0]   wr_stb,
    output logic [ADDR_W-1:0] cap_addr,
    output logic              cap_rw,
    output logic [DATA_W-1:0] cap_data,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic              opfetch_stb,
    output logic              nmi_n
);

    localparam int NMI_CW = $clog2(NMI_WIDTH);

    typedef enum logic {NMI_IDLE, NMI_ACTIVE} nmi_state_t;

    logic [SYNC_STAGES-1:0]             r_phi2_sync;
    logic [SYNC_STAGES-1:0]             r_rw_sync;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] r_a_sync;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_d_sync;
    logic [1:0]                         r_phi2_hist;

    logic              w_phi2;
    logic              w_rw;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_rise;
    logic              w_fall;
    logic [NWIN-1:0]   w_match;

    logic [NWIN-1:0]   r_win_hit;
    logic [NWIN-1:0]   r_rd_stb;
    logic [NWIN-1:0]   r_wr_stb;
    logic [ADDR_W-1:0] r_cap_addr;
    logic              r_cap_rw;
    logic [DATA_W-1:0] r_cap_data;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic              r_cycle_valid;

    nmi_state_t        r_nmi_state;
    logic [NMI_CW-1:0] r_nmi_cnt;
    logic              r_nmi_n;

    // PHI2 chain and history reset high: a PHI2 already high at reset release must not look like a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phi2_sync <= '1;
            r_rw_sync   <= '1;
            r_a_sync    <= '0;
            r_d_sync    <= '0;
            r_phi2_hist <= 2'b11;
        end else begin
            r_phi2_sync <= {r_phi2_sync[SYNC_STAGES-2:0], phi2_async};
            r_rw_sync   <= {r_rw_sync[SYNC_STAGES-2:0], rw_async};
            r_a_sync    <= {r_a_sync[SYNC_STAGES-2:0], a_async};
            r_d_sync    <= {r_d_sync[SYNC_STAGES-2:0], d_async};
            r_phi2_hist <= {r_phi2_hist[0], w_phi2};
        end
    end

    assign w_phi2 = r_phi2_sync[SYNC_STAGES-1];
    assign w_rw   = r_rw_sync[SYNC_STAGES-1];
    assign w_addr = r_a_sync[SYNC_STAGES-1];
    assign w_data = r_d_sync[SYNC_STAGES-1];
    assign w_rise = (r_phi2_hist == 2'b01);
    assign w_fall = (r_phi2_hist == 2'b10);

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        w_match = '0;
        for (int i = NWIN - 1; i >= 0; i--) begin
            if ((w_addr & WIN_MASK[i*ADDR_W +: ADDR_W]) == WIN_PATTERN[i*ADDR_W +: ADDR_W]) begin
                w_match    = '0;
                w_match[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_hit     <= '0;
            r_rd_stb      <= '0;
            r_wr_stb      <= '0;
            r_cap_addr    <= '0;
            r_cap_rw      <= 1'b1;
            r_cap_data    <= '0;
            r_cycle_cnt   <= '0;
            r_cycle_valid <= 1'b0;
        end else begin
            r_rd_stb <= '0;
            r_wr_stb <= '0;
            if (w_rise) begin
                r_cap_addr    <= w_addr;
                r_cap_rw      <= w_rw;
                r_cycle_valid <= 1'b1;
                r_win_hit     <= w_match;
                if (w_rw) begin
                    r_rd_stb <= w_match;
                end
            end else if (w_fall && r_cycle_valid) begin
                if (!r_cap_rw) begin
                    r_cap_data <= w_data;
                    r_wr_stb   <= r_win_hit;
                end
                r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
                r_cycle_valid <= 1'b0;
            end
        end
    end

`ifdef BUS_CYCLE_DECODER_OPFETCH_EN
    logic [SYNC_STAGES-1:0] r_sync_sync;
    logic                   r_opfetch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_sync <= '0;
            r_opfetch   <= 1'b0;
        end else begin
            r_sync_sync <= {r_sync_sync[SYNC_STAGES-2:0], sync_async};
            r_opfetch   <= w_rise & w_rw & r_sync_sync[SYNC_STAGES-1];
        end
    end

    assign opfetch_stb = r_opfetch;
`else
    logic w_unused_sync;
    assign w_unused_sync = sync_async;
    assign opfetch_stb   = 1'b0;
`endif

    // Requests arriving while the pulse is running are dropped, not queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nmi_state <= NMI_IDLE;
            r_nmi_cnt   <= '0;
            r_nmi_n     <= 1'b1;
        end else begin
            case (r_nmi_state)
                NMI_IDLE: begin
                    if (step_req) begin
                        r_nmi_state <= NMI_ACTIVE;
                        r_nmi_cnt   <= NMI_CW'(NMI_WIDTH - 1);
                        r_nmi_n     <= 1'b0;
                    end
                end
                NMI_ACTIVE: begin
                    if (r_nmi_cnt == '0) begin
                        r_nmi_state <= NMI_IDLE;
                        r_nmi_n     <= 1'b1;
                    end else begin
                        r_nmi_cnt <= r_nmi_cnt - NMI_CW'(1);
                    end
                end
                default: r_nmi_state <= NMI_IDLE;
            endcase
        end
    end

    assign win_hit   = r_win_hit;
    assign rd_stb    = r_rd_stb;
    assign wr_stb    = r_wr_stb;
    assign cap_addr  = r_cap_addr;
    assign cap_rw    = r_cap_rw;
    assign cap_data  = r_cap_data;
    assign cycle_cnt = r_cycle_cnt;
    assign nmi_n     = r_nmi_n;

endmodule

// File: tb/tb_bus_cycle_decoder.sv
// Bench for bus_cycle_decoder: randomized 6502 bus cycles checked every clk against an
// event-scheduled model of the decoder, plus hand-computed checks of the directed scenarios.
`timescale 1ns/1ps
module tb_bus_cycle_decoder;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int NWIN   = 2;
  localparam int SS     = 2;
  localparam int NMI_W  = 128;
  localparam int LAT    = SS + 2;
  localparam logic [NWIN*ADDR_W-1:0] MASKS = {16'h8000, 16'hFF00};
  localparam logic [NWIN*ADDR_W-1:0] PATS  = {16'h8000, 16'hFF00};

  // model's own window table: index 0 = FPGA page, index 1 = RAM upper half
  logic [ADDR_W-1:0] win_mask [NWIN] = '{16'hFF00, 16'h8000};
  logic [ADDR_W-1:0] win_pat  [NWIN] = '{16'hFF00, 16'h8000};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic phi2_async = 1'b0, rw_async = 1'b1, sync_async = 1'b0, step_req = 1'b0;
  logic [ADDR_W-1:0] a_async = '0;
  logic [DATA_W-1:0] d_async = '0;

  logic [NWIN-1:0] win_hit, rd_stb, wr_stb, win_hit4, rd_stb4, wr_stb4;
  logic [ADDR_W-1:0] cap_addr, cap_addr4;
  logic [DATA_W-1:0] cap_data, cap_data4;
  logic cap_rw, cap_rw4, opfetch_stb, opfetch_stb4, nmi_n, nmi_n4;
  logic [15:0] cycle_cnt;
  logic [3:0] cycle_cnt4;

  bus_cycle_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NWIN(NWIN), .WIN_MASK(MASKS),
    .WIN_PATTERN(PATS), .SYNC_STAGES(SS), .NMI_WIDTH(NMI_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .phi2_async(phi2_async), .rw_async(rw_async),
    .sync_async(sync_async), .a_async(a_async), .d_async(d_async), .step_req(step_req),
    .win_hit(win_hit), .rd_stb(rd_stb), .wr_stb(wr_stb), .cap_addr(cap_addr),
    .cap_rw(cap_rw), .cap_data(cap_data), .cycle_cnt(cycle_cnt),
    .opfetch_stb(opfetch_stb), .nmi_n(nmi_n));

  bus_cycle_decoder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NWIN(NWIN), .WIN_MASK(MASKS),
    .WIN_PATTERN(PATS), .SYNC_STAGES(SS), .NMI_WIDTH(NMI_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .phi2_async(phi2_async), .rw_async(rw_async),
    .sync_async(sync_async), .a_async(a_async), .d_async(d_async), .step_req(step_req),
    .win_hit(win_hit4), .rd_stb(rd_stb4), .wr_stb(wr_stb4), .cap_addr(cap_addr4),
    .cap_rw(cap_rw4), .cap_data(cap_data4), .cycle_cnt(cycle_cnt4),
    .opfetch_stb(opfetch_stb4), .nmi_n(nmi_n4));

  // ---------------- clock / reset ----------------
  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  typedef struct {
    int              when;
    bit              rise;
    logic [ADDR_W-1:0] addr;
    bit              rw;
    logic [DATA_W-1:0] data;
    bit              sync;
  } ev_t;

  ev_t ev_q[$];

  logic [NWIN-1:0]   m_hit = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_rw = 1'b1;
  logic [DATA_W-1:0] m_data = '0;
  logic [15:0]       m_cnt = '0;
  bit                m_valid = 1'b0;
  int                nmi_first = 0;
  int                nmi_last = -1;
  logic [NWIN-1:0]   e_rd, e_wr;
  logic              e_op, e_nmi;

  int n_cmp = 0;
  int n_err = 0;
  int rd_p0 = 0, rd_p1 = 0, wr_p0 = 0, wr_p1 = 0, op_p = 0, op_coinc = 0, nmi_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NWIN-1:0] win_of(input logic [ADDR_W-1:0] a);
    for (int i = 0; i < NWIN; i++)
      if ((a & win_mask[i]) == win_pat[i]) return NWIN'(1) << i;
    return '0;
  endfunction

  // ---------------- scoreboard: compare every clk ----------------
  always @(negedge clk) begin
    e_rd = '0;
    e_wr = '0;
    e_op = 1'b0;
    if (!rst_n) begin
      ev_q.delete();
      m_hit = '0; m_addr = '0; m_rw = 1'b1; m_data = '0; m_cnt = '0; m_valid = 1'b0;
      nmi_first = 0; nmi_last = -1;
    end else begin
      while (ev_q.size() > 0 && ev_q[0].when <= cyc) begin
        ev_t e;
        e = ev_q.pop_front();
        if (e.rise) begin
          m_addr = e.addr; m_rw = e.rw; m_valid = 1'b1; m_hit = win_of(e.addr);
          if (e.rw) e_rd = m_hit;
`ifdef BUS_CYCLE_DECODER_OPFETCH_EN
          e_op = e.rw & e.sync;
`endif
        end else if (m_valid) begin
          if (!m_rw) begin
            m_data = e.data;
            e_wr = m_hit;
          end
          m_cnt = m_cnt + 16'd1;
          m_valid = 1'b0;
        end
      end
    end
    e_nmi = (cyc >= nmi_first && cyc <= nmi_last) ? 1'b0 : 1'b1;

    check("win_hit",   32'(win_hit),    32'(m_hit));
    check("rd_stb",    32'(rd_stb),     32'(e_rd));
    check("wr_stb",    32'(wr_stb),     32'(e_wr));
    check("cap_addr",  32'(cap_addr),   32'(m_addr));
    check("cap_rw",    32'(cap_rw),     32'(m_rw));
    check("cap_data",  32'(cap_data),   32'(m_data));
    check("cycle_cnt", 32'(cycle_cnt),  32'(m_cnt));
    check("cycle_cnt4",32'(cycle_cnt4), 32'(m_cnt[3:0]));
    check("opfetch",   32'(opfetch_stb),32'(e_op));
    check("nmi_n",     32'(nmi_n),      32'(e_nmi));

    if (rd_stb[0]) rd_p0++;
    if (rd_stb[1]) rd_p1++;
    if (wr_stb[0]) wr_p0++;
    if (wr_stb[1]) wr_p1++;
    if (opfetch_stb) op_p++;
    if (opfetch_stb && rd_stb[0]) op_coinc++;
    if (rst_n && !nmi_n) nmi_low++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_ev(input bit rise, input logic [ADDR_W-1:0] a, input bit rw,
                         input logic [DATA_W-1:0] d, input bit s);
    ev_t e;
    e.when = cyc + LAT; e.rise = rise; e.addr = a; e.rw = rw; e.data = d; e.sync = s;
    ev_q.push_back(e);
  endtask

  task automatic bus_cycle(input logic [ADDR_W-1:0] a, input bit rw,
                           input logic [DATA_W-1:0] d, input bit s);
    a_async = a; rw_async = rw; d_async = d; sync_async = s;
    tick(2);
    phi2_async = 1'b1;
    push_ev(1'b1, a, rw, d, s);
    tick(int'($urandom_range(3, 8)));
    phi2_async = 1'b0;
    push_ev(1'b0, a, rw, d, s);
    tick(int'($urandom_range(3, 6)));
  endtask

  task automatic rand_cycle();
    logic [ADDR_W-1:0] a;
    a = 16'($urandom);
    case ($urandom_range(0, 3))
      0: a[15:8] = 8'hFF;
      1: a[15] = 1'b1;
      2: a[15] = 1'b0;
      default: ;
    endcase
    bus_cycle(a, 1'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic step();
    step_req = 1'b1;
    if (cyc + 1 > nmi_last) begin
      nmi_first = cyc + 1;
      nmi_last  = cyc + NMI_W;
    end
    tick(1);
    step_req = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
    tick(1);
  endtask

  // ---------------- directed + random stimulus ----------------
  int b_rd0, b_rd1, b_wr0, b_wr1, b_op, b_co, b_nmi;

  task automatic snap();
    b_rd0 = rd_p0; b_rd1 = rd_p1; b_wr0 = wr_p0; b_wr1 = wr_p1;
    b_op = op_p; b_co = op_coinc; b_nmi = nmi_low;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(4);
    check("rst_cap_rw", 32'(cap_rw), 32'd1);
    check("rst_nmi_n", 32'(nmi_n), 32'd1);
    check("rst_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_win_hit", 32'(win_hit), 32'd0);
    check("rst_cap_addr", 32'(cap_addr), 32'd0);
    rst_n = 1'b1;
    tick(2);

    snap();
    bus_cycle(16'hFF12, 1'b1, 8'h00, 1'b0);
    tick(6);
    check("t1_win_hit", 32'(win_hit), 32'h1);
    check("t1_cap_addr", 32'(cap_addr), 32'hFF12);
    check("t1_cap_rw", 32'(cap_rw), 32'd1);
    check("t1_rd0_pulses", 32'(rd_p0 - b_rd0), 32'd1);
    check("t1_rd1_pulses", 32'(rd_p1 - b_rd1), 32'd0);
    check("t1_cnt", 32'(cycle_cnt), 32'd1);

    snap();
    bus_cycle(16'h8034, 1'b0, 8'hA5, 1'b0);
    tick(6);
    check("t2_wr1_pulses", 32'(wr_p1 - b_wr1), 32'd1);
    check("t2_wr0_pulses", 32'(wr_p0 - b_wr0), 32'd0);
    check("t2_cap_data", 32'(cap_data), 32'hA5);
    check("t2_cap_rw", 32'(cap_rw), 32'd0);
    check("t2_rd_pulses", 32'(rd_p0 + rd_p1 - b_rd0 - b_rd1), 32'd0);
    check("t2_win_hit", 32'(win_hit), 32'h2);

    snap();
    bus_cycle(16'h1234, 1'b1, 8'h00, 1'b0);
    tick(6);
    check("t3_win_hit", 32'(win_hit), 32'h0);
    check("t3_strobes", 32'(rd_p0 + rd_p1 + wr_p0 + wr_p1 - b_rd0 - b_rd1 - b_wr0 - b_wr1), 32'd0);
    check("t3_cnt", 32'(cycle_cnt), 32'd3);

    // reset while PHI2 is high: the following fall must not count
    a_async = 16'h8100; rw_async = 1'b1;
    tick(2);
    phi2_async = 1'b1;
    push_ev(1'b1, 16'h8100, 1'b1, 8'h00, 1'b0);
    tick(8);
    do_reset(3);
    snap();
    tick(6);
    phi2_async = 1'b0;
    push_ev(1'b0, 16'h8100, 1'b1, 8'h00, 1'b0);
    tick(8);
    check("t4_cnt_after_orphan_fall", 32'(cycle_cnt), 32'd0);
    check("t4_strobes", 32'(rd_p0 + rd_p1 + wr_p0 + wr_p1 - b_rd0 - b_rd1 - b_wr0 - b_wr1), 32'd0);
    bus_cycle(16'hFF40, 1'b0, 8'h3C, 1'b0);
    tick(6);
    check("t4_cnt_fresh", 32'(cycle_cnt), 32'd1);
    check("t4_wr0_pulses", 32'(wr_p0 - b_wr0), 32'd1);

    // single-step: second request 50 clk later is ignored
    snap();
    step();
    tick(49);
    step();
    tick(200);
    check("t5_nmi_low_clks", 32'(nmi_low - b_nmi), 32'd128);
    check("t5_nmi_n", 32'(nmi_n), 32'd1);

    // 17 cycles wrap the 4-bit counter to 1
    do_reset(3);
    for (int i = 0; i < 17; i++) rand_cycle();
    tick(6);
    check("t6_cnt4", 32'(cycle_cnt4), 32'd1);
    check("t6_cnt16", 32'(cycle_cnt), 32'd17);

    snap();
    bus_cycle(16'hFF00, 1'b1, 8'h00, 1'b1);
    tick(6);
`ifdef BUS_CYCLE_DECODER_OPFETCH_EN
    check("t7_op_pulses", 32'(op_p - b_op), 32'd1);
    check("t7_op_with_rd0", 32'(op_coinc - b_co), 32'd1);
`else
    check("t7_op_pulses", 32'(op_p - b_op), 32'd0);
`endif
    check("t7_rd0_pulses", 32'(rd_p0 - b_rd0), 32'd1);

    for (int i = 0; i < 60; i++) begin
      rand_cycle();
      if ($urandom_range(0, 7) == 0) step();
    end
    tick(NMI_W + 10);

`ifndef BUS_CYCLE_DECODER_OPFETCH_EN
    check("opfetch_total", 32'(op_p), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
